// File: rtl/arcade_input_cond.sv
// -----------------------------------------------------------------------------
// arcade_input_cond
// Conditions raw MiSTer joystick bits before they reach the game core.
//   - 1 ms prescaler producing tick_1ms
//   - 2-flop synchroniser + tick-based debounce on 10 raw bits
//   - pause button toggles a pause_request level on each debounced press
//   - each coin slot queues debounced presses (up to COIN_QMAX) and replays
//     them as COIN_PULSE_MS high pulses separated by COIN_GAP_MS low gaps
// Ports (all in clk_sys domain, all outputs registered):
//   clk_sys, reset (sync, active-high)
//   joy_dir_in[3:0] {up,down,left,right}, fire_in, start_in[1:0], coin_in[1:0],
//   pause_btn_in                                   -> raw active-high inputs
//   joy_dir[3:0], fire, start[1:0]                 -> debounced levels
//   coin[1:0]                                      -> shaped coin pulses
//   pause_request                                  -> toggled pause level
//   tick_1ms                                       -> 1-cycle strobe per tick
// -----------------------------------------------------------------------------
module arcade_input_cond #(
  parameter int unsigned TICK_DIV      = 18000,
  parameter int unsigned DEBOUNCE_MS   = 4,
  parameter int unsigned COIN_PULSE_MS = 100,
  parameter int unsigned COIN_GAP_MS   = 50,
  parameter int unsigned COIN_QMAX     = 3
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [3:0] joy_dir_in,
  input  logic       fire_in,
  input  logic [1:0] start_in,
  input  logic [1:0] coin_in,
  input  logic       pause_btn_in,
  output logic [3:0] joy_dir,
  output logic       fire,
  output logic [1:0] start,
  output logic [1:0] coin,
  output logic       pause_request,
  output logic       tick_1ms
);

  localparam int unsigned NB = 10;
  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(TICK_DIV - 1);
  localparam logic [3:0]    DB_LAST   = 4'(DEBOUNCE_MS - 1);
  localparam logic [7:0]    PULSE_LD  = 8'(COIN_PULSE_MS);
  localparam logic [7:0]    GAP_LD    = 8'(COIN_GAP_MS);
  localparam logic [1:0]    QMAX_V    = 2'(COIN_QMAX);

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_PULSE = 2'd1,
    C_GAP   = 2'd2
  } coin_state_e;

  // ---------------- prescaler ----------------
  logic [CW-1:0] div_q, div_d;
  logic          tick_q, tick_d;

  // Next prescaler count; the strobe is registered so it lands on the wrap.
  always_comb begin
    div_d  = div_q;
    tick_d = 1'b0;
    if (div_q == DIV_LAST) begin
      div_d  = '0;
      tick_d = 1'b1;
    end else begin
      div_d  = div_q + CW'(1);
      tick_d = 1'b0;
    end
  end

  // Prescaler state register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  // ---------------- synchroniser + debounce ----------------
  // Bit map: [3:0] dir, [4] fire, [6:5] start, [8:7] coin, [9] pause.
  logic [NB-1:0]      raw_s;
  logic [NB-1:0]      sync1_q, sync2_q;
  logic [NB-1:0]      stable_q, stable_d;
  logic [NB-1:0][3:0] dbc_q, dbc_d;

  assign raw_s = {pause_btn_in, coin_in, start_in, fire_in, joy_dir_in};

  // Per-bit debounce: count ticks of disagreement, flip after DEBOUNCE_MS.
  always_comb begin
    stable_d = stable_q;
    dbc_d    = dbc_q;
    for (int b = 0; b < int'(NB); b++) begin
      if (sync2_q[b] == stable_q[b]) begin
        dbc_d[b] = 4'd0;
      end else if (tick_q) begin
        if (dbc_q[b] == DB_LAST) begin
          stable_d[b] = ~stable_q[b];
          dbc_d[b]    = 4'd0;
        end else begin
          dbc_d[b] = dbc_q[b] + 4'd1;
        end
      end else begin
        dbc_d[b] = dbc_q[b];
      end
    end
  end

  // Synchroniser and debounce state registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      dbc_q    <= '0;
    end else begin
      sync1_q  <= raw_s;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      dbc_q    <= dbc_d;
    end
  end

  // ---------------- level outputs, edge detect, pause ----------------
  logic [6:0] ctl_q;
  logic [2:0] prev_q;   // previous debounced {pause, coin2, coin1}
  logic [2:0] rise_s;
  logic       pause_q;

  assign rise_s = stable_q[9:7] & ~prev_q;

  // Registered control levels, edge history and pause toggle.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ctl_q   <= '0;
      prev_q  <= '0;
      pause_q <= 1'b0;
    end else begin
      ctl_q   <= stable_q[6:0];
      prev_q  <= stable_q[9:7];
      pause_q <= pause_q ^ rise_s[2];
    end
  end

  // ---------------- coin shaping, one instance per slot ----------------
  for (genvar s = 0; s < 2; s++) begin : g_coin
    coin_state_e st_q, st_d;
    logic [7:0]  tmr_q, tmr_d;
    logic [1:0]  cq_q, cq_d;
    logic        coin_q, coin_d;
    logic        deq_s;
    logic [1:0]  after_deq_s;

    // Coin FSM next state; the queue frees a slot before accepting an edge.
    always_comb begin
      st_d   = st_q;
      tmr_d  = tmr_q;
      coin_d = coin_q;
      deq_s  = 1'b0;
      case (st_q)
        C_IDLE: begin
          if (cq_q != 2'd0) begin
            deq_s  = 1'b1;
            st_d   = C_PULSE;
            tmr_d  = PULSE_LD;
            coin_d = 1'b1;
          end else begin
            deq_s  = 1'b0;
          end
        end
        C_PULSE: begin
          if (tick_q) begin
            if (tmr_q == 8'd1) begin
              coin_d = 1'b0;
              tmr_d  = GAP_LD;
              st_d   = C_GAP;
            end else begin
              tmr_d = tmr_q - 8'd1;
            end
          end else begin
            tmr_d = tmr_q;
          end
        end
        C_GAP: begin
          if (tick_q) begin
            if (tmr_q == 8'd1) begin
              tmr_d = 8'd0;
              st_d  = C_IDLE;
            end else begin
              tmr_d = tmr_q - 8'd1;
            end
          end else begin
            tmr_d = tmr_q;
          end
        end
        default: begin
          st_d   = C_IDLE;
          tmr_d  = 8'd0;
          coin_d = 1'b0;
        end
      endcase
      after_deq_s = cq_q - {1'b0, deq_s};
      if (rise_s[s] && (after_deq_s != QMAX_V)) begin
        cq_d = after_deq_s + 2'd1;
      end else begin
        cq_d = after_deq_s;
      end
    end

    // Coin FSM, timer, queue and output register.
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        st_q   <= C_IDLE;
        tmr_q  <= 8'd0;
        cq_q   <= 2'd0;
        coin_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        tmr_q  <= tmr_d;
        cq_q   <= cq_d;
        coin_q <= coin_d;
      end
    end

    assign coin[s] = coin_q;
  end

  assign joy_dir       = ctl_q[3:0];
  assign fire          = ctl_q[4];
  assign start         = ctl_q[6:5];
  assign pause_request = pause_q;
  assign tick_1ms      = tick_q;

endmodule
